// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back arbiter and its
// round-robin sub-arbiter: default widths, the hard-wired zero register
// and the requester index map.
package regfile_wb_arbiter_pkg;

    localparam int ADDR_SIZE_DEF = 5;
    localparam int WORD_SIZE_DEF = 32;
    localparam int CNT_WIDTH_DEF = 16;

    // Architectural zero register; writes to it must never land.
    localparam int ZERO_REG = 0;

    // Requester positions inside the two-bit valid/grant vectors.
    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;

    // Which requester wins when both ask in the same cycle.
    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_LD  = 1'b1
    } rr_pri_e;

    // One-hot pick between two requesters given the current priority.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input rr_pri_e pri);
        logic [1:0] grant;
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (pri == PRI_ALU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational from the valids,
// the hold input and the internal priority pointer; the pointer flips to
// the other requester after every grant, whether or not that requester
// is currently asking.
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_hold,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    rr_pri_e    r_rr_ptr;
    logic [1:0] w_grant;

    // Grant selection: nothing while frozen, otherwise round-robin pick.
    always_comb begin
        w_grant = 2'b00;
        if (!i_hold) begin
            w_grant = rr_pick(i_valid, r_rr_ptr);
        end
    end

    // Pointer moves to the requester that did not just win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= PRI_ALU;
        end else if (w_grant[REQ_ALU]) begin
            r_rr_ptr <= PRI_LD;
        end else if (w_grant[REQ_LD]) begin
            r_rr_ptr <= PRI_ALU;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the ALU and the load
// unit. Accepted writes are registered (one cycle latency) before they
// reach the regfile; writes to the zero register can be swallowed, and a
// saturating counter records cycles in which both units competed.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE   = ADDR_SIZE_DEF,
    parameter int WORD_SIZE   = WORD_SIZE_DEF,
    parameter bit ZERO_REG_RO = 1'b1,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_hold,
    input  logic                 i_req0_valid,
    input  logic [ADDR_SIZE-1:0] i_req0_addr,
    input  logic [WORD_SIZE-1:0] i_req0_data,
    output logic                 o_req0_ready,
    input  logic                 i_req1_valid,
    input  logic [ADDR_SIZE-1:0] i_req1_addr,
    input  logic [WORD_SIZE-1:0] i_req1_data,
    output logic                 o_req1_ready,
    output logic                 o_rf_w_en,
    output logic [ADDR_SIZE-1:0] o_rf_waddr,
    output logic [WORD_SIZE-1:0] o_rf_wdata,
    output logic [CNT_WIDTH-1:0] o_conflict_cnt
);

    logic [1:0]           w_valid;
    logic [1:0]           w_grant;
    logic                 w_xfer;
    logic [ADDR_SIZE-1:0] w_sel_addr;
    logic [WORD_SIZE-1:0] w_sel_data;
    logic                 w_zero_hit;
    logic                 w_conflict;

    logic                 r_w_en;
    logic [ADDR_SIZE-1:0] r_waddr;
    logic [WORD_SIZE-1:0] r_wdata;
    logic [CNT_WIDTH-1:0] r_conflict_cnt;

    assign w_valid[REQ_ALU] = i_req0_valid;
    assign w_valid[REQ_LD]  = i_req1_valid;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_hold  (i_hold),
        .i_valid (w_valid),
        .o_grant (w_grant)
    );

    assign o_req0_ready = w_grant[REQ_ALU];
    assign o_req1_ready = w_grant[REQ_LD];

    assign w_xfer     = |w_grant;
    assign w_sel_addr = w_grant[REQ_LD] ? i_req1_addr : i_req0_addr;
    assign w_sel_data = w_grant[REQ_LD] ? i_req1_data : i_req0_data;
    assign w_zero_hit = ZERO_REG_RO && (w_sel_addr == ADDR_SIZE'(ZERO_REG));
    assign w_conflict = i_req0_valid && i_req1_valid && !i_hold;

    // Output stage: stage the accepted write for the regfile; address and
    // data keep their last value when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_en  <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_w_en <= w_xfer && !w_zero_hit;
            if (w_xfer) begin
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
        end
    end

    // Conflict counter: counts contended, unfrozen cycles and sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != {CNT_WIDTH{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + 1'b1;
        end
    end

    assign o_rf_w_en      = r_w_en;
    assign o_rf_waddr     = r_waddr;
    assign o_rf_wdata     = r_wdata;
    assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter. Two instances share one stimulus stream:
// A uses the defaults, B disables the zero-register filter and uses a
// 4-bit conflict counter. A behavioural model tracks who should win and
// what the regfile port must show; directed scenarios pin known values.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        req0Valid;
    logic [4:0]  req0Addr;
    logic [31:0] req0Data;
    logic        req1Valid;
    logic [4:0]  req1Addr;
    logic [31:0] req1Data;

    logic        rdy0A, rdy1A, wenA;
    logic [4:0]  waddrA;
    logic [31:0] wdataA;
    logic [15:0] cntA;

    logic        rdy0B, rdy1B, wenB;
    logic [4:0]  waddrB;
    logic [31:0] wdataB;
    logic [3:0]  cntB;

    int checks;
    int failures;

    regfile_wb_arbiter dutA (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_hold         (hold),
        .i_req0_valid   (req0Valid),
        .i_req0_addr    (req0Addr),
        .i_req0_data    (req0Data),
        .o_req0_ready   (rdy0A),
        .i_req1_valid   (req1Valid),
        .i_req1_addr    (req1Addr),
        .i_req1_data    (req1Data),
        .o_req1_ready   (rdy1A),
        .o_rf_w_en      (wenA),
        .o_rf_waddr     (waddrA),
        .o_rf_wdata     (wdataA),
        .o_conflict_cnt (cntA)
    );

    regfile_wb_arbiter #(
        .ZERO_REG_RO (1'b0),
        .CNT_WIDTH   (4)
    ) dutB (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_hold         (hold),
        .i_req0_valid   (req0Valid),
        .i_req0_addr    (req0Addr),
        .i_req0_data    (req0Data),
        .o_req0_ready   (rdy0B),
        .i_req1_valid   (req1Valid),
        .i_req1_addr    (req1Addr),
        .i_req1_data    (req1Data),
        .o_req1_ready   (rdy1B),
        .o_rf_w_en      (wenB),
        .o_rf_waddr     (waddrB),
        .o_rf_wdata     (wdataB),
        .o_conflict_cnt (cntB)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: whose turn it is on a tie, what the write port shows
    // this cycle, and the running count of contended cycles.
    int          mTurn;
    bit          mWenA;
    bit          mWenB;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    int          mCntA;
    int          mCntB;

    // Which requester is accepted in the current cycle, -1 for none.
    function automatic int expGrant();
        if (hold) return -1;
        if (req0Valid && req1Valid) return mTurn;
        if (req0Valid) return 0;
        if (req1Valid) return 1;
        return -1;
    endfunction

    // Advance the model on every rising edge; reset clears it at once.
    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            mTurn = 0;
            mWenA = 1'b0;
            mWenB = 1'b0;
            mAddr = '0;
            mData = '0;
            mCntA = 0;
            mCntB = 0;
        end else begin
            g = expGrant();
            if (req0Valid && req1Valid && !hold) begin
                if (mCntA < 65535) mCntA = mCntA + 1;
                if (mCntB < 15) mCntB = mCntB + 1;
            end
            if (g >= 0) begin
                mTurn = 1 - g;
                mAddr = (g == 1) ? req1Addr : req0Addr;
                mData = (g == 1) ? req1Data : req0Data;
                mWenA = (mAddr != 5'd0);
                mWenB = 1'b1;
            end else begin
                mWenA = 1'b0;
                mWenB = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    task automatic compareModel();
        int g;
        g = expGrant();
        checkOutput("A.ready0", 64'(rdy0A), 64'(g == 0));
        checkOutput("A.ready1", 64'(rdy1A), 64'(g == 1));
        checkOutput("B.ready0", 64'(rdy0B), 64'(g == 0));
        checkOutput("B.ready1", 64'(rdy1B), 64'(g == 1));
        checkOutput("A.w_en", 64'(wenA), 64'(mWenA));
        checkOutput("B.w_en", 64'(wenB), 64'(mWenB));
        checkOutput("A.waddr", 64'(waddrA), 64'(mAddr));
        checkOutput("B.waddr", 64'(waddrB), 64'(mAddr));
        checkOutput("A.wdata", 64'(wdataA), 64'(mData));
        checkOutput("B.wdata", 64'(wdataB), 64'(mData));
        checkOutput("A.cnt", 64'(cntA), 64'(mCntA));
        checkOutput("B.cnt", 64'(cntB), 64'(mCntB));
    endtask

    // Drive one cycle's inputs just after the rising edge, then compare
    // everything on the falling edge of that cycle.
    task automatic applyStimulus(input logic h, input logic v0, input logic [4:0] a0,
                                 input logic [31:0] d0, input logic v1,
                                 input logic [4:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        hold      = h;
        req0Valid = v0;
        req0Addr  = a0;
        req0Data  = d0;
        req1Valid = v1;
        req1Addr  = a1;
        req1Data  = d1;
        @(negedge clk);
        compareModel();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        hold      = 1'b0;
        req0Valid = 1'b0;
        req1Valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("reset.w_en", 64'(wenA), 64'd0);
        checkOutput("reset.waddr", 64'(waddrA), 64'd0);
        checkOutput("reset.wdata", 64'(wdataA), 64'd0);
        checkOutput("reset.cntA", 64'(cntA), 64'd0);
        checkOutput("reset.cntB", 64'(cntB), 64'd0);
        @(negedge clk);
        compareModel();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic        nv0, nv1, nh;
        logic [4:0]  na0, na1;
        logic [31:0] nd0, nd1;
        int          g;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        hold      = 1'b0;
        req0Valid = 1'b0;
        req0Addr  = '0;
        req0Data  = '0;
        req1Valid = 1'b0;
        req1Addr  = '0;
        req1Data  = '0;
        #12;
        doReset();

        // Single ALU request: accepted now, visible next cycle, gone after.
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        checkOutput("single.ready0", 64'(rdy0A), 64'd1);
        checkOutput("single.ready1", 64'(rdy1A), 64'd0);
        idleCycle();
        checkOutput("single.w_en", 64'(wenA), 64'd1);
        checkOutput("single.waddr", 64'(waddrA), 64'd5);
        checkOutput("single.wdata", 64'(wdataA), 64'hDEADBEEF);
        idleCycle();
        checkOutput("single.w_en_after", 64'(wenA), 64'd0);
        checkOutput("single.waddr_kept", 64'(waddrA), 64'd5);

        // Round robin from a fresh pointer: grants 0,1,0,1.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
            checkOutput("rr.ready0", 64'(rdy0A), 64'((i % 2) == 0));
            checkOutput("rr.ready1", 64'(rdy1A), 64'((i % 2) == 1));
            if (i > 0) begin
                checkOutput("rr.waddr_lag", 64'(waddrA), 64'(((i % 2) == 1) ? 1 : 2));
            end
        end
        idleCycle();
        checkOutput("rr.waddr_last", 64'(waddrA), 64'd2);
        checkOutput("rr.cnt", 64'(cntA), 64'd4);

        // Reset while a write is staged: it must vanish immediately.
        applyStimulus(1'b0, 1'b1, 5'd9, 32'hAAAA5555, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        req0Valid = 1'b0;
        checkOutput("rstmid.w_en_staged", 64'(wenA), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid.w_en_dropped", 64'(wenA), 64'd0);
        checkOutput("rstmid.cnt", 64'(cntA), 64'd0);
        @(negedge clk);
        compareModel();
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        checkOutput("rstmid.ptr_ready0", 64'(rdy0A), 64'd1);
        idleCycle();
        checkOutput("rstmid.cnt_after", 64'(cntA), 64'd1);
        checkOutput("rstmid.waddr", 64'(waddrA), 64'd3);

        // Zero register: A swallows the write, B lets it through.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        checkOutput("zero.ready1", 64'(rdy1A), 64'd1);
        idleCycle();
        checkOutput("zero.A_w_en", 64'(wenA), 64'd0);
        checkOutput("zero.B_w_en", 64'(wenB), 64'd1);
        checkOutput("zero.B_waddr", 64'(waddrB), 64'd0);
        checkOutput("zero.B_wdata", 64'(wdataB), 64'h1234);

        // Hold: pointer left at LD by a lone ALU grant must survive a freeze.
        doReset();
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd6, 32'h6, 1'b1, 5'd7, 32'h7);
            checkOutput("hold.ready0", 64'(rdy0A), 64'd0);
            checkOutput("hold.ready1", 64'(rdy1A), 64'd0);
            checkOutput("hold.cnt", 64'(cntA), 64'd0);
            if (i > 0) checkOutput("hold.w_en", 64'(wenA), 64'd0);
        end
        applyStimulus(1'b0, 1'b1, 5'd6, 32'h6, 1'b1, 5'd7, 32'h7);
        checkOutput("hold.release_ready1", 64'(rdy1A), 64'd1);
        checkOutput("hold.release_ready0", 64'(rdy0A), 64'd0);
        idleCycle();
        checkOutput("hold.waddr", 64'(waddrA), 64'd7);
        checkOutput("hold.cnt_after", 64'(cntA), 64'd1);

        // Saturation of the narrow counter after 20 contended cycles.
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        end
        idleCycle();
        checkOutput("sat.cntB", 64'(cntB), 64'd15);
        checkOutput("sat.cntA", 64'(cntA), 64'd20);
        idleCycle();
        checkOutput("sat.cntB_held", 64'(cntB), 64'd15);

        // Randomized traffic; requesters keep a request stable until accepted.
        for (int c = 0; c < 3000; c++) begin
            g   = expGrant();
            nv0 = req0Valid;
            na0 = req0Addr;
            nd0 = req0Data;
            nv1 = req1Valid;
            na1 = req1Addr;
            nd1 = req1Data;
            if (!req0Valid || g == 0) begin
                nv0 = ($urandom_range(0, 3) != 0);
                na0 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                nd0 = $urandom;
            end
            if (!req1Valid || g == 1) begin
                nv1 = ($urandom_range(0, 3) != 0);
                na1 = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                nd1 = $urandom;
            end
            nh = ($urandom_range(0, 7) == 0);
            applyStimulus(nh, nv0, na0, nd0, nv1, na1, nd1);
        end
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
